// File: rtl/btd_arbiter.sv
// Round-robin arbiter that shares one binary-to-BCD converter among N_REQ requesters.
// Optional macro BTD_ARB_STATS_EN adds a saturating handshake counter output (conv_count).

package Pkg_Global;
    localparam int unsigned N      = 8;
    localparam int unsigned LENGTH = 12;
endpackage

module btd #(
    parameter int unsigned N      = 8,
    parameter int unsigned LENGTH = 12
) (
    input  logic [N-1:0]      bin,
    output logic [LENGTH-1:0] bcd
);
    logic [N+LENGTH-1:0] sh;

    // Double dabble: add 3 to any digit >= 5 before each shift.
    always_comb begin
        sh = '0;
        sh[N-1:0] = bin;
        for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned d = 0; d < LENGTH / 4; d++) begin
                if (sh[N+4*d +: 4] >= 4'd5)
                    sh[N+4*d +: 4] = sh[N+4*d +: 4] + 4'd3;
            end
            sh = sh << 1;
        end
        bcd = sh[N +: LENGTH];
    end
endmodule

module btd_arbiter
    import Pkg_Global::*;
#(
    parameter  int unsigned N_REQ = 2,
    localparam int unsigned ID_W  = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*N-1:0] bin_data,
    output logic [N_REQ-1:0]   ack,
    output logic [LENGTH-1:0]  dec_data,
    output logic [ID_W-1:0]    dec_id,
    output logic               dec_valid,
    input  logic               dec_ready
`ifdef BTD_ARB_STATS_EN
    ,
    output logic [15:0]        conv_count
`endif
);
    typedef enum logic [1:0] {IDLE, CONV, VALID} state_t;

    state_t            state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   gid;
    logic [N-1:0]      op_reg;
    logic [ID_W-1:0]   grant;
    logic              found;
    int unsigned       scan_idx;
    logic [LENGTH-1:0] bcd;

    btd #(.N(N), .LENGTH(LENGTH)) u_btd (
        .bin (op_reg),
        .bcd (bcd)
    );

    // First pending request at or above ptr, wrapping around.
    always_comb begin
        found    = 1'b0;
        grant    = '0;
        scan_idx = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            scan_idx = (32'(ptr) + i) % N_REQ;
            if (!found && req[scan_idx]) begin
                found = 1'b1;
                grant = ID_W'(scan_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gid       <= '0;
            op_reg    <= '0;
            ack       <= '0;
            dec_data  <= '0;
            dec_id    <= '0;
            dec_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack <= '0;
                    if (found) begin
                        op_reg <= bin_data[grant*N +: N];
                        gid    <= grant;
                        ack    <= N_REQ'(1) << grant;
                        state  <= CONV;
                    end
                end
                CONV: begin
                    ack       <= '0;
                    dec_data  <= bcd;
                    dec_id    <= gid;
                    dec_valid <= 1'b1;
                    ptr       <= (gid == ID_W'(N_REQ - 1)) ? '0 : gid + 1'b1;
                    state     <= VALID;
                end
                VALID: begin
                    ack <= '0;
                    if (dec_ready) begin
                        dec_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    ack       <= '0;
                    dec_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef BTD_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)
            conv_count <= '0;
        else if (dec_valid && dec_ready && conv_count != 16'hFFFF)
            conv_count <= conv_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_btd_arbiter.sv
// Directed self-checking bench for btd_arbiter with N_REQ=2, N=8, LENGTH=12.
// Define BTD_ARB_STATS_EN for both files to exercise the conv_count counter.
`timescale 1ns/1ps
module tb_btd_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [15:0] bin_data;
    logic [1:0]  ack;
    logic [11:0] dec_data;
    logic [0:0]  dec_id;
    logic        dec_valid;
    logic        dec_ready;
`ifdef BTD_ARB_STATS_EN
    logic [15:0] conv_count;
`endif

    int vectors    = 0;
    int miscompares = 0;

    btd_arbiter #(.N_REQ(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .bin_data  (bin_data),
        .ack       (ack),
        .dec_data  (dec_data),
        .dec_id    (dec_id),
        .dec_valid (dec_valid),
        .dec_ready (dec_ready)
`ifdef BTD_ARB_STATS_EN
        ,
        .conv_count(conv_count)
`endif
    );

    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1ns after the rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; dec_ready = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bin_data = '0;
        rst = 1'b1; req = '0; dec_ready = 1'b0;
        cycle(); cycle();
        rst = 1'b0;
        vectors++;
        if (ack !== 2'b00 || dec_valid !== 1'b0 || dec_data !== 12'h000 || dec_id !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: ack=%b valid=%b data=%h id=%0d, want 00 0 000 0",
                     ack, dec_valid, dec_data, dec_id);
        end
    endtask

    task automatic test_single();
        do_reset();
        bin_data[7:0] = 8'd255; req = 2'b01; dec_ready = 1'b0;
        cycle();
        vectors++;
        if (ack !== 2'b01 || dec_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_ack: ack=%b valid=%b, want 01 0", ack, dec_valid);
        end
        req = 2'b00;
        cycle();
        vectors++;
        if (dec_valid !== 1'b1 || dec_data !== 12'h255 || dec_id !== 1'b0 || ack !== 2'b00) begin
            miscompares++;
            $display("FAIL single_result: valid=%b data=%h id=%0d ack=%b, want 1 255 0 00",
                     dec_valid, dec_data, dec_id, ack);
        end
        for (int i = 0; i < 5; i++) begin
            bin_data[7:0] = 8'd3;
            cycle();
            vectors++;
            if (dec_valid !== 1'b1 || dec_data !== 12'h255 || dec_id !== 1'b0 || ack !== 2'b00) begin
                miscompares++;
                $display("FAIL single_hold[%0d]: valid=%b data=%h id=%0d ack=%b, want 1 255 0 00",
                         i, dec_valid, dec_data, dec_id, ack);
            end
        end
        dec_ready = 1'b1;
        cycle();
        dec_ready = 1'b0;
        vectors++;
        if (dec_valid !== 1'b0 || dec_data !== 12'h255) begin
            miscompares++;
            $display("FAIL single_clear: valid=%b data=%h, want 0 255", dec_valid, dec_data);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_ack [3] = '{2'b01, 2'b10, 2'b01};
        logic [11:0] exp_data[3] = '{12'h010, 12'h099, 12'h010};
        logic [0:0]  exp_id  [3] = '{1'b0, 1'b1, 1'b0};
        logic [1:0]  got_ack [3];
        int          ack_cyc [3];
        logic [11:0] got_data[3];
        logic [0:0]  got_id  [3];
        int n_ack = 0;
        int n_res = 0;
        do_reset();
        bin_data = {8'd99, 8'd10}; req = 2'b11; dec_ready = 1'b1;
        for (int c = 0; c < 15 && n_res < 3; c++) begin
            cycle();
            if (ack !== 2'b00 && n_ack < 3) begin
                got_ack[n_ack] = ack; ack_cyc[n_ack] = c; n_ack++;
            end
            if (dec_valid === 1'b1 && n_res < 3) begin
                got_data[n_res] = dec_data; got_id[n_res] = dec_id; n_res++;
            end
        end
        req = 2'b00;
        cycle();
        dec_ready = 1'b0;
        vectors++;
        if (n_ack != 3 || n_res != 3) begin
            miscompares++;
            $display("FAIL rr_count: acks=%0d results=%0d, want 3 3", n_ack, n_res);
        end else begin
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (got_ack[k] !== exp_ack[k] || got_data[k] !== exp_data[k] || got_id[k] !== exp_id[k]) begin
                    miscompares++;
                    $display("FAIL rr_order[%0d]: ack=%b data=%h id=%0d, want %b %h %0d",
                             k, got_ack[k], got_data[k], got_id[k], exp_ack[k], exp_data[k], exp_id[k]);
                end
            end
            vectors++;
            if (ack_cyc[1] - ack_cyc[0] != 3 || ack_cyc[2] - ack_cyc[1] != 3) begin
                miscompares++;
                $display("FAIL rr_spacing: gaps=%0d,%0d, want 3,3",
                         ack_cyc[1] - ack_cyc[0], ack_cyc[2] - ack_cyc[1]);
            end
        end
    endtask

    task automatic test_wait_in_valid();
        int early = 0;
        do_reset();
        bin_data = {8'd7, 8'd5}; req = 2'b01; dec_ready = 1'b0;
        cycle();
        req = 2'b10;
        cycle();
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (ack !== 2'b00) early++;
        end
        vectors++;
        if (early != 0) begin
            miscompares++;
            $display("FAIL wait_no_ack: early acks=%0d, want 0", early);
        end
        dec_ready = 1'b1;
        cycle();
        dec_ready = 1'b0;
        vectors++;
        if (ack !== 2'b00 || dec_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wait_handshake: ack=%b valid=%b, want 00 0", ack, dec_valid);
        end
        cycle();
        vectors++;
        if (ack !== 2'b10) begin
            miscompares++;
            $display("FAIL wait_ack1: ack=%b, want 10", ack);
        end
        req = 2'b00;
        cycle();
        vectors++;
        if (dec_valid !== 1'b1 || dec_data !== 12'h007 || dec_id !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_result: valid=%b data=%h id=%0d, want 1 007 1", dec_valid, dec_data, dec_id);
        end
        dec_ready = 1'b1;
        cycle();
        dec_ready = 1'b0;
    endtask

    task automatic test_reset_in_conv();
        do_reset();
        bin_data = {8'd2, 8'd1}; req = 2'b01; dec_ready = 1'b0;
        cycle();
        req = 2'b00; rst = 1'b1;
        cycle();
        rst = 1'b0;
        vectors++;
        if (dec_valid !== 1'b0 || dec_data !== 12'h000 || ack !== 2'b00) begin
            miscompares++;
            $display("FAIL conv_reset: valid=%b data=%h ack=%b, want 0 000 00", dec_valid, dec_data, ack);
        end
        req = 2'b10;
        cycle();
        vectors++;
        if (ack !== 2'b10) begin
            miscompares++;
            $display("FAIL conv_reset_ack: ack=%b, want 10", ack);
        end
        req = 2'b00;
        cycle();
        vectors++;
        if (dec_valid !== 1'b1 || dec_id !== 1'b1 || dec_data !== 12'h002) begin
            miscompares++;
            $display("FAIL conv_reset_result: valid=%b id=%0d data=%h, want 1 1 002", dec_valid, dec_id, dec_data);
        end
        dec_ready = 1'b1;
        cycle();
        dec_ready = 1'b0;
        // After granting id1 the pointer wraps to 0, so a double request goes to id0.
        req = 2'b11;
        cycle();
        req = 2'b00;
        vectors++;
        if (ack !== 2'b01) begin
            miscompares++;
            $display("FAIL conv_reset_wrap: ack=%b, want 01", ack);
        end
        cycle();
        dec_ready = 1'b1;
        cycle();
        dec_ready = 1'b0;
    endtask

    task automatic test_boundaries();
        logic [7:0]  vals[3] = '{8'd0, 8'd128, 8'd9};
        logic [11:0] exps[3] = '{12'h000, 12'h128, 12'h009};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            bin_data[7:0] = vals[k]; req = 2'b01; dec_ready = 1'b1;
            cycle();
            req = 2'b00;
            cycle();
            vectors++;
            if (dec_valid !== 1'b1 || dec_data !== exps[k]) begin
                miscompares++;
                $display("FAIL boundary[%0d]: valid=%b data=%h, want 1 %h", k, dec_valid, dec_data, exps[k]);
            end
            cycle();
        end
        dec_ready = 1'b0;
        #1 req = 2'b01;
        #2 req = 2'b00;
        cycle();
        vectors++;
        if (ack !== 2'b00) begin
            miscompares++;
            $display("FAIL drop_ack: ack=%b, want 00", ack);
        end
        cycle();
        vectors++;
        if (dec_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_valid: valid=%b, want 0", dec_valid);
        end
    endtask

`ifdef BTD_ARB_STATS_EN
    task automatic handshake_once();
        bin_data[7:0] = 8'd1; req = 2'b01; dec_ready = 1'b1;
        cycle();
        req = 2'b00;
        cycle();
        cycle();
        dec_ready = 1'b0;
    endtask

    task automatic test_stats();
        do_reset();
        vectors++;
        if (conv_count !== 16'd0) begin
            miscompares++;
            $display("FAIL stats_reset: count=%0d, want 0", conv_count);
        end
        for (int k = 0; k < 3; k++) handshake_once();
        vectors++;
        if (conv_count !== 16'd3) begin
            miscompares++;
            $display("FAIL stats_count: count=%0d, want 3", conv_count);
        end
        force dut.conv_count = 16'hFFFF;
        cycle();
        release dut.conv_count;
        cycle();
        handshake_once();
        vectors++;
        if (conv_count !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL stats_saturate: count=%h, want ffff", conv_count);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; req = '0; bin_data = '0; dec_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_wait_in_valid();
        test_reset_in_conv();
        test_boundaries();
`ifdef BTD_ARB_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1);
    end
endmodule
